// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA-256 chaining-state accumulator.
// Latency: n/a (constants, types and a constant helper function only).
// Backpressure: n/a.
package sha_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;

    // SHA-256 initial hash value, word 0 (H0) at the LSBs.
    localparam logic [NUM_WORDS*WORD_W-1:0] SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2
    } acc_state_t;

    // IV word for chaining-word index idx. Indices beyond the SHA-256 set
    // (wider parametrisations) start from zero.
    function automatic logic [WORD_W-1:0] iv_word(input int idx);
        if (idx >= 0 && idx < NUM_WORDS) begin
            return SHA256_IV[idx*WORD_W +: WORD_W];
        end
        return '0;
    endfunction

endpackage

// File: rtl/sha_word_acc.sv
// One chaining word: holds H_i and adds the matching working variable into it.
// Latency: 1 cycle from add_en/load/reinit to the updated h.
// Backpressure: none; accepts an update every cycle.
module sha_word_acc
    import sha_pkg::*;
#(
    parameter int               WIDTH   = WORD_W,
    parameter logic [WIDTH-1:0] IV_WORD = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,      // new message: take init_val
    input  logic [WIDTH-1:0] init_val,  // IV word or midstate word
    input  logic             reinit,    // pass-1 done: return to IV for pass 2
    input  logic             add_en,    // accumulate add_val this cycle
    input  logic [WIDTH-1:0] add_val,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] sum        // h + add_val, for digest capture
);

    // Modulo-2^WIDTH add; the carry out of the word is dropped.
    assign sum = h + add_val;

    // Word register: a new message beats the pass-2 re-init, which beats accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= IV_WORD;
        end else if (load) begin
            h <= init_val;
        end else if (reinit) begin
            h <= IV_WORD;
        end else if (add_en) begin
            h <= sum;
        end
    end

endmodule

// File: rtl/sha_state_accumulator.sv
// SHA chaining-state accumulator: adds engine working variables into H after each block.
// Latency: 1 cycle from upd_valid to updated h_out; digest_valid 1 cycle after last block.
// Backpressure: none; upd_valid is accepted on every cycle while busy, ignored in IDLE.
module sha_state_accumulator
    import sha_pkg::*;
#(
    parameter int WORDS     = NUM_WORDS,
    parameter int WIDTH     = WORD_W,
    parameter int CNT_W     = 8,
    parameter int DOUBLE_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mid_load,
    input  logic [WORDS*WIDTH-1:0] mid_in,
    input  logic                   dbl,
    input  logic                   upd_valid,
    input  logic                   upd_last,
    input  logic [WORDS*WIDTH-1:0] work_in,
    output logic [WORDS*WIDTH-1:0] h_out,
    output logic [WORDS*WIDTH-1:0] first_digest,
    output logic [WORDS*WIDTH-1:0] digest,
    output logic                   digest_valid,
    output logic                   busy,
    output logic                   pass2,
    output logic [CNT_W-1:0]       blk_cnt
);

    acc_state_t state;
    acc_state_t state_nxt;

    logic                   dbl_r;
    logic                   restart;
    logic                   blk_fire;
    logic                   blk_last;
    logic                   to_pass2;
    logic                   finish;
    logic [WORDS*WIDTH-1:0] sum_all;

    // A new message (either kind) overrides anything else in the same cycle,
    // so a block arriving together with start/mid_load is dropped.
    assign restart  = start | mid_load;
    assign blk_fire = busy & upd_valid & ~restart;
    assign blk_last = blk_fire & upd_last;
    assign to_pass2 = blk_last & (state == PASS1) & dbl_r;
    assign finish   = blk_last & ~to_pass2;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: restart always lands in PASS1; last block either chains to PASS2 or ends.
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = PASS1;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                PASS1:   if (blk_last) state_nxt = dbl_r ? PASS2 : IDLE;
                PASS2:   if (blk_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy  = 1'b0;
        pass2 = 1'b0;
        case (state)
            PASS1:   busy = 1'b1;
            PASS2: begin
                busy  = 1'b1;
                pass2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Double-hash request is latched at message start; forced off when the mode is absent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbl_r <= 1'b0;
        end else if (restart) begin
            dbl_r <= dbl & (DOUBLE_EN != 0);
        end
    end

    // Block counter: a midstate already accounts for one block; pass 2 counts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (restart) begin
            blk_cnt <= mid_load ? CNT_W'(1) : '0;
        end else if (to_pass2) begin
            blk_cnt <= '0;
        end else if (blk_fire) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
        end
    end

    // Result registers: pass-1 digest kept for the second hash, final digest plus a one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_digest <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= finish;
            if (to_pass2) begin
                first_digest <= sum_all;
            end
            if (finish) begin
                digest <= sum_all;
            end
        end
    end

    // One independent word accumulator per chaining word; no carry crosses words.
    for (genvar i = 0; i < WORDS; i++) begin : g_word
        localparam logic [WIDTH-1:0] IVW = WIDTH'(iv_word(i));

        sha_word_acc #(
            .WIDTH   (WIDTH),
            .IV_WORD (IVW)
        ) u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (restart),
            .init_val (mid_load ? mid_in[i*WIDTH +: WIDTH] : IVW),
            .reinit   (to_pass2),
            .add_en   (blk_fire),
            .add_val  (work_in[i*WIDTH +: WIDTH]),
            .h        (h_out[i*WIDTH +: WIDTH]),
            .sum      (sum_all[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_sha_state_accumulator.sv
// Self-checking bench for sha_state_accumulator: directed cases plus randomized traffic.
// Stimulus changes 1 time unit after the rising edge; state is sampled 1 unit after that.
// A negedge monitor pops expected digests from a queue whenever digest_valid is seen.
module tb_sha_state_accumulator;

    localparam int VW = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            mid_load;
    logic [VW-1:0]   mid_in;
    logic            dbl;
    logic            upd_valid;
    logic            upd_last;
    logic [VW-1:0]   work_in;
    logic [VW-1:0]   h_out;
    logic [VW-1:0]   first_digest;
    logic [VW-1:0]   digest;
    logic            digest_valid;
    logic            busy;
    logic            pass2;
    logic [7:0]      blk_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: eight 32-bit words, word 0 = index 0.
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
    logic [7:0][31:0] m_h;
    logic [7:0][31:0] m_first;
    logic [7:0][31:0] m_digest;
    logic [7:0]       m_cnt;
    bit               m_busy;
    bit               m_pass2;
    bit               m_dbl;
    logic [VW-1:0]    exp_q[$];

    always #5 clk = ~clk;

    sha_state_accumulator #(
        .WORDS     (8),
        .WIDTH     (32),
        .CNT_W     (8),
        .DOUBLE_EN (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mid_load     (mid_load),
        .mid_in       (mid_in),
        .dbl          (dbl),
        .upd_valid    (upd_valid),
        .upd_last     (upd_last),
        .work_in      (work_in),
        .h_out        (h_out),
        .first_digest (first_digest),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy),
        .pass2        (pass2),
        .blk_cnt      (blk_cnt)
    );

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][31:0] rnd_words();
        logic [7:0][31:0] r;
        for (int i = 0; i < 8; i++) r[i] = $urandom();
        return r;
    endfunction

    // Message rules: new message beats blocks, mid_load beats start, blocks only count while busy.
    task automatic model_apply(input bit st, input bit ml, input bit d, input logic [7:0][31:0] mid,
                               input bit uv, input bit ul, input logic [7:0][31:0] w);
        logic [7:0][31:0] s;
        if (st || ml) begin
            m_dbl   = d;
            m_busy  = 1'b1;
            m_pass2 = 1'b0;
            m_h     = ml ? mid : IV;
            m_cnt   = ml ? 8'd1 : 8'd0;
        end else if (m_busy && uv) begin
            for (int i = 0; i < 8; i++) s[i] = m_h[i] + w[i];
            m_cnt = m_cnt + 8'd1;
            if (ul && !m_pass2 && m_dbl) begin
                m_first = s;
                m_h     = IV;
                m_cnt   = 8'd0;
                m_pass2 = 1'b1;
            end else if (ul) begin
                m_h      = s;
                m_digest = s;
                m_busy   = 1'b0;
                m_pass2  = 1'b0;
                exp_q.push_back(s);
            end else begin
                m_h = s;
            end
        end
    endtask

    task automatic model_reset();
        m_h      = IV;
        m_first  = '0;
        m_digest = '0;
        m_cnt    = '0;
        m_busy   = 1'b0;
        m_pass2  = 1'b0;
        m_dbl    = 1'b0;
    endtask

    task automatic check_state();
        chk("h_out", h_out, m_h);
        chk("blk_cnt", VW'(blk_cnt), VW'(m_cnt));
        chk("busy", VW'(busy), VW'(m_busy));
        chk("pass2", VW'(pass2), VW'(m_pass2));
        chk("first_digest", first_digest, m_first);
        chk("digest_hold", digest, m_digest);
    endtask

    // One clock of stimulus: present inputs, advance the model, clock, drop pulses, compare.
    task automatic drive(input bit st, input bit ml, input bit d, input logic [7:0][31:0] mid,
                         input bit uv, input bit ul, input logic [7:0][31:0] w);
        start     = st;
        mid_load  = ml;
        dbl       = d;
        mid_in    = mid;
        upd_valid = uv;
        upd_last  = ul;
        work_in   = w;
        model_apply(st, ml, d, mid, uv, ul, w);
        @(posedge clk);
        #1;
        start     = 1'b0;
        mid_load  = 1'b0;
        upd_valid = 1'b0;
        upd_last  = 1'b0;
        #1;
        check_state();
    endtask

    task automatic do_start(input bit d);
        drive(1'b1, 1'b0, d, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_blk(input logic [7:0][31:0] w, input bit last);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, last, w);
    endtask

    // Scoreboard monitor: every digest_valid must match the oldest expected digest.
    initial begin
        logic [VW-1:0] e;
        forever begin
            @(negedge clk);
            if (digest_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_digest_valid: got pulse digest=%h want no pulse", digest);
                end else begin
                    e = exp_q.pop_front();
                    chk("digest", digest, e);
                end
            end
        end
    end

    initial begin
        logic [7:0][31:0] w;
        logic [7:0][31:0] mid;
        int r;
        bit st;
        bit ml;
        bit uv;
        bit ul;

        rst_n     = 1'b0;
        start     = 1'b0;
        mid_load  = 1'b0;
        dbl       = 1'b0;
        mid_in    = '0;
        upd_valid = 1'b0;
        upd_last  = 1'b0;
        work_in   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        chk("reset_digest_valid", VW'(digest_valid), '0);
        rst_n = 1'b1;

        // 1: single zero block -> digest equals IV.
        do_start(1'b0);
        do_blk('0, 1'b1);
        chk("t1_digest_w0", VW'(digest[31:0]), VW'(32'h6a09e667));
        chk("t1_digest_w4", VW'(digest[159:128]), VW'(32'h510e527f));
        chk("t1_busy", VW'(busy), '0);

        // 2: per-word wrap with no carry into neighbouring words.
        do_start(1'b0);
        w = '0;
        w[4] = 32'haef1ad81;
        w[0] = 32'h00000001;
        do_blk(w, 1'b1);
        chk("t2_digest_w4", VW'(digest[159:128]), VW'(32'h00000000));
        chk("t2_digest_w0", VW'(digest[31:0]), VW'(32'h6a09e668));
        chk("t2_digest_w5", VW'(digest[191:160]), VW'(32'h9b05688c));

        // 3: two-block message.
        do_start(1'b0);
        w = '0;
        w[0] = 32'h1;
        do_blk(w, 1'b0);
        chk("t3_h_w0", VW'(h_out[31:0]), VW'(32'h6a09e668));
        chk("t3_cnt1", VW'(blk_cnt), VW'(8'd1));
        do_blk(w, 1'b1);
        chk("t3_digest_w0", VW'(digest[31:0]), VW'(32'h6a09e669));
        chk("t3_cnt2", VW'(blk_cnt), VW'(8'd2));

        // 4: double hash.
        do_start(1'b1);
        w = '0;
        w[0] = 32'h10;
        do_blk(w, 1'b1);
        chk("t4_first_w0", VW'(first_digest[31:0]), VW'(32'h6a09e677));
        chk("t4_pass2", VW'(pass2), VW'(1'b1));
        chk("t4_h_iv_w0", VW'(h_out[31:0]), VW'(32'h6a09e667));
        do_blk('0, 1'b1);
        chk("t4_digest_w0", VW'(digest[31:0]), VW'(32'h6a09e667));

        // 5: externally loaded midstate.
        mid = '0;
        mid[0] = 32'h11111111;
        drive(1'b0, 1'b1, 1'b0, mid, 1'b0, 1'b0, '0);
        w = '0;
        w[0] = 32'h1;
        do_blk(w, 1'b1);
        chk("t5_digest_w0", VW'(digest[31:0]), VW'(32'h11111112));
        chk("t5_digest_w1", VW'(digest[63:32]), VW'(32'h0));

        // 6a: asynchronous reset in the middle of PASS1.
        do_start(1'b0);
        do_blk(rnd_words(), 1'b0);
        do_blk(rnd_words(), 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_state();
        chk("t6_rst_digest_valid", VW'(digest_valid), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_state();

        // 6b: start together with upd_valid drops the block.
        do_start(1'b0);
        do_blk(rnd_words(), 1'b0);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, rnd_words());
        chk("t6_h_iv_w0", VW'(h_out[31:0]), VW'(32'h6a09e667));
        chk("t6_cnt0", VW'(blk_cnt), '0);

        // start and mid_load together: midstate wins; idle blocks ignored afterwards.
        drive(1'b1, 1'b1, 1'b0, rnd_words(), 1'b0, 1'b0, '0);
        do_blk(rnd_words(), 1'b1);
        do_blk(rnd_words(), 1'b1);

        // Block counter wrap at 256.
        do_start(1'b0);
        for (int i = 0; i < 258; i++) do_blk(rnd_words(), 1'b0);
        do_blk(rnd_words(), 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            r  = $urandom_range(0, 99);
            st = (r < 4) || (r == 8);
            ml = (r >= 4 && r < 9);
            uv = ($urandom_range(0, 99) < 70);
            ul = ($urandom_range(0, 3) == 0);
            drive(st, ml, 1'($urandom_range(0, 1)), rnd_words(), uv, ul, rnd_words());
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", VW'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
